module_hamming_ctrl: RTL and testbench



---
 rtl/hamming_pkg.sv | 7 +
 rtl/module_hamming_ctrl_if.sv | 26 ++
 rtl/module_hold_timer.sv | 17 +
 rtl/module_hamming_ctrl.sv | 84 ++++++++
 tb/tb_module_hamming_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths and FSM state type for the Hamming(7,4) sequencer
package hamming_pkg;
  localparam int DATA_W = 4;
  localparam int WORD_W = 7;
  localparam int SYN_W  = 3;
  typedef enum logic [2:0] {IDLE, ENC, INJ, CHK, HOLD} state_t;
endpackage

// File: rtl/module_hamming_ctrl_if.sv
// module_hamming_ctrl_if: request, datapath and result signals of the Hamming sequencer
interface module_hamming_ctrl_if import hamming_pkg::*; #(parameter int CNT_W = 8);
  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic [WORD_W-1:0] err_mask_i;
  logic [DATA_W-1:0] enc_data_o;
  logic [WORD_W-1:0] enc_word_i;
  logic [WORD_W-1:0] chk_word_o;
  logic [SYN_W-1:0]  syndrome_i;
  logic [DATA_W-1:0] corrected_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;
  logic [DATA_W-1:0] led_o;
  logic              error_o;
  logic              miscorr_o;
  logic [CNT_W-1:0]  err_cnt_o;
  modport master (
    output start_i, data_i, err_mask_i, enc_word_i, syndrome_i, corrected_i,
    input  enc_data_o, chk_word_o, busy_o, done_o, result_o, led_o, error_o, miscorr_o, err_cnt_o
  );
  modport slave (
    input  start_i, data_i, err_mask_i, enc_word_i, syndrome_i, corrected_i,
    output enc_data_o, chk_word_o, busy_o, done_o, result_o, led_o, error_o, miscorr_o, err_cnt_o
  );
endinterface

// File: rtl/module_hold_timer.sv
// module_hold_timer: loadable down-counter timing the result hold window
module module_hold_timer #(parameter int HOLD_CYCLES = 4) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  localparam int W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  logic [W-1:0] cnt_q;
  // load HOLD_CYCLES-1 so the zero flag rises on the last hold cycle
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else if (load_i) cnt_q <= W'(HOLD_CYCLES - 1);
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/module_hamming_ctrl.sv
// module_hamming_ctrl: sequences encode, error injection, check and result hold
module module_hamming_ctrl import hamming_pkg::*; #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  module_hamming_ctrl_if.slave bus
);
  state_t            state_q;
  logic [DATA_W-1:0] data_q;
  logic [WORD_W-1:0] mask_q;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] chk_q;
  logic [DATA_W-1:0] result_q;
  logic              error_q;
  logic              miscorr_q;
  logic              done_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hold_zero;
  module_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (state_q == CHK),
    .dec_i   (state_q == HOLD),
    .zero_o  (hold_zero)
  );
  // transaction sequencer; results persist until the next check
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      miscorr_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start_i) begin
          data_q  <= bus.data_i;
          mask_q  <= bus.err_mask_i;
          busy_q  <= 1'b1;
          state_q <= ENC;
        end
        ENC: begin
          word_q  <= bus.enc_word_i;
          state_q <= INJ;
        end
        INJ: begin
          chk_q   <= word_q ^ mask_q;
          state_q <= CHK;
        end
        CHK: begin
          result_q  <= bus.corrected_i;
          error_q   <= |bus.syndrome_i;
          miscorr_q <= bus.corrected_i != data_q;
          if (|bus.syndrome_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
          done_q    <= 1'b1;
          state_q   <= HOLD;
        end
        HOLD: if (hold_zero) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.enc_data_o = data_q;
  assign bus.chk_word_o = chk_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.led_o      = result_q;
  assign bus.error_o    = error_q;
  assign bus.miscorr_o  = miscorr_q;
  assign bus.err_cnt_o  = cnt_q;
endmodule

// File: tb/tb_module_hamming_ctrl.sv
// tb_module_hamming_ctrl: scoreboard bench with a Hamming(7,4) datapath model
module tb_module_hamming_ctrl;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  module_hamming_ctrl_if #(.CNT_W(8)) m ();
  module_hamming_ctrl_if #(.CNT_W(2)) s ();
  module_hamming_ctrl #(.HOLD_CYCLES(H), .CNT_W(8)) u_dut (.clk_i(clk), .rst_n_i(rst_n), .bus(m));
  module_hamming_ctrl #(.HOLD_CYCLES(H), .CNT_W(2)) u_sat (.clk_i(clk), .rst_n_i(rst_n), .bus(s));
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction
  function automatic logic [2:0] syn(input logic [6:0] w);
    return {w[3] ^ w[4] ^ w[5] ^ w[6], w[1] ^ w[2] ^ w[5] ^ w[6], w[0] ^ w[2] ^ w[4] ^ w[6]};
  endfunction
  function automatic logic [3:0] cor(input logic [6:0] w);
    logic [2:0] sy;
    logic [6:0] c;
    sy = syn(w);
    c = sy != 3'd0 ? w ^ (7'b1 << (sy - 3'd1)) : w;
    return {c[6], c[5], c[4], c[2]};
  endfunction
  assign m.enc_word_i  = enc(m.enc_data_o);
  assign m.syndrome_i  = syn(m.chk_word_o);
  assign m.corrected_i = cor(m.chk_word_o);
  assign s.enc_word_i  = enc(s.enc_data_o);
  assign s.syndrome_i  = syn(s.chk_word_o);
  assign s.corrected_i = cor(s.chk_word_o);
  assign s.start_i     = m.start_i;
  assign s.data_i      = m.data_i;
  assign s.err_mask_i  = m.err_mask_i;
  typedef struct {
    logic [3:0] dat;
    logic [6:0] chk;
    logic [3:0] res;
    logic       err;
    logic       mis;
    logic [7:0] cnt;
    logic [1:0] sat;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] cnt_m = '0;
  logic [1:0] sat_m = '0;
  logic [3:0] last_res = '0;
  logic prev_done = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [3:0] d, input logic [6:0] msk);
    exp_t x;
    x.dat = d;
    x.chk = enc(d) ^ msk;
    x.res = cor(x.chk);
    x.err = syn(x.chk) != 3'd0;
    x.mis = x.res != d;
    if (x.err && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
    if (x.err && sat_m != 2'd3) sat_m = sat_m + 2'd1;
    x.cnt = cnt_m;
    x.sat = sat_m;
    last_res = x.res;
    sb.push_back(x);
  endtask
  task automatic start_txn(input logic [3:0] d, input logic [6:0] msk);
    m.start_i = 1'b1;
    m.data_i = d;
    m.err_mask_i = msk;
    push(d, msk);
    @(negedge clk);
    m.start_i = 1'b0;
    m.data_i = 4'($urandom);
    m.err_mask_i = 7'($urandom);
  endtask
  task automatic finish_txn(input bit poke);
    int cyc;
    for (cyc = 1; cyc < 12 && !m.done_o; cyc++) begin
      if (poke) begin
        m.start_i = cyc <= 3;
        m.data_i = 4'hF;
      end
      @(negedge clk);
    end
    m.start_i = 1'b0;
    check("latency", cyc, 4);
    for (; cyc < 4 + H + 4 && m.busy_o; cyc++) @(negedge clk);
    check("busy_low_cyc", cyc, 4 + H);
    check("hold_result", m.result_o, last_res);
    @(negedge clk);
    check("idle_stay", m.busy_o, 0);
  endtask
  // scoreboard consumer: each done pulse retires the oldest expected transaction
  always @(negedge clk) begin
    if (rst_n && m.done_o) begin
      check("done_pulse", prev_done, 0);
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check("enc_data", m.enc_data_o, e.dat);
        check("chk_word", m.chk_word_o, e.chk);
        check("result", m.result_o, e.res);
        check("led", m.led_o, e.res);
        check("error", m.error_o, e.err);
        check("miscorr", m.miscorr_o, e.mis);
        check("err_cnt", m.err_cnt_o, e.cnt);
        check("sat_cnt", s.err_cnt_o, e.sat);
        check("sat_result", s.result_o, e.res);
      end
    end
    prev_done = m.done_o;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    m.start_i = 1'b0;
    m.data_i = '0;
    m.err_mask_i = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", m.busy_o, 0);
    check("rst_done", m.done_o, 0);
    check("rst_result", m.result_o, 0);
    check("rst_error", m.error_o, 0);
    check("rst_cnt", m.err_cnt_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_txn(4'hB, 7'h00);
    finish_txn(0);
    for (int k = 0; k < 7; k++) begin
      start_txn(4'h5, 7'b1 << k);
      finish_txn(0);
    end
    check("cnt_after_single", m.err_cnt_o, 7);
    start_txn(4'h3, 7'b0000011);
    finish_txn(0);
    start_txn(4'h6, 7'h10);
    finish_txn(1);
    m.start_i = 1'b1;
    m.data_i = 4'h9;
    m.err_mask_i = 7'h00;
    push(4'h9, 7'h00);
    push(4'h9, 7'h00);
    for (int c = 1; c <= 4 + H + 4; c++) begin
      @(negedge clk);
      if (c == 4 + H + 1) m.start_i = 1'b0;
      if (c == 4) check("rt_done1", m.done_o, 1);
      if (c == 4 + H) check("rt_idle", m.busy_o, 0);
      if (c == 4 + H + 1) check("rt_busy", m.busy_o, 1);
      if (c == 4 + H + 4) check("rt_done2", m.done_o, 1);
    end
    for (int c = 0; c < 20 && m.busy_o; c++) @(negedge clk);
    check("rt_end", m.busy_o, 0);
    start_txn(4'hA, 7'h04);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", m.busy_o, 0);
    check("arst_result", m.result_o, 0);
    check("arst_error", m.error_o, 0);
    check("arst_miscorr", m.miscorr_o, 0);
    check("arst_cnt", m.err_cnt_o, 0);
    check("arst_chk", m.chk_word_o, 0);
    check("arst_enc", m.enc_data_o, 0);
    sb.delete();
    cnt_m = '0;
    sat_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_txn(4'h7, 7'h40);
    finish_txn(0);
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
